// File: rtl/adder_pipelined_structural.sv
// Pipelined ripple-carry add/subtract unit: each stage ripples one CW-bit chunk
// through full-adder cells and registers the chunk carry for the next stage.

module adder_pipelined_structural_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_pipelined_structural #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic [WIDTH-1:0] A_DI,
    input  logic [WIDTH-1:0] B_DI,
    input  logic             C_DI,
    input  logic             Sub_SI,
    input  logic             InValid_SI,
    output logic             InReady_SO,
    output logic [WIDTH-1:0] S_DO,
    output logic             C_DO,
    output logic             V_DO,
    output logic             Z_DO,
    output logic             OutValid_SO,
    input  logic             OutReady_SI
);
    localparam int CW = WIDTH / STAGES;

    // Valid/ready: a beat moves on a rising edge when valid & ready are both high.
    // The whole pipeline advances as one; it only holds when a result sits
    // unconsumed at the output.
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance    = OutReady_SI | ~OutValid_SO;
    assign InReady_SO = advance;
    assign b_eff      = Sub_SI ? ~B_DI : B_DI;
    assign cin_eff    = Sub_SI | C_DI;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;       // result bits finished before this stage
        localparam int RW = WIDTH - LO;   // operand bits still to be processed

        logic [RW-1:0]      a_in;
        logic [RW-1:0]      b_in;
        logic               c_in;
        logic               vld_in;
        logic [CW:0]        cy;
        logic [CW-1:0]      sum_c;
        logic [LO+CW-1:0]   s_d;
        logic [LO+CW-1:0]   s_q;
        logic               c_q;
        logic               vld_q;

        if (k == 0) begin : g_first
            assign a_in   = A_DI;
            assign b_in   = b_eff;
            assign c_in   = cin_eff;
            assign vld_in = InValid_SI;
            assign s_d    = sum_c;
        end else begin : g_next
            assign a_in   = g_stage[k-1].g_skew.a_q;
            assign b_in   = g_stage[k-1].g_skew.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign vld_in = g_stage[k-1].vld_q;
            assign s_d    = {sum_c, g_stage[k-1].s_q};
        end

        assign cy[0] = c_in;
        for (genvar i = 0; i < CW; i++) begin : g_bit
            adder_pipelined_structural_fa u_fa (
                .a_i (a_in[i]),
                .b_i (b_in[i]),
                .c_i (cy[i]),
                .s_o (sum_c[i]),
                .c_o (cy[i+1])
            );
        end

        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_in;
                s_q   <= s_d;
                c_q   <= cy[CW];
            end
        end

        // Upper operand chunks ride forward until their stage comes up.
        if (k < STAGES - 1) begin : g_skew
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;

            always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
                if (!Rst_RBI) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[RW-1:CW];
                    b_q <= b_in[RW-1:CW];
                end
            end
        end

        if (k == STAGES - 1) begin : g_flags
            logic v_d;
            logic z_d;
            logic v_q;
            logic z_q;

            assign v_d = (a_in[CW-1] == b_in[CW-1]) & (sum_c[CW-1] != a_in[CW-1]);
            assign z_d = ~|s_d;

            always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
                if (!Rst_RBI) begin
                    v_q <= 1'b0;
                    z_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_d;
                    z_q <= z_d;
                end
            end
        end
    end

    assign S_DO        = g_stage[STAGES-1].s_q;
    assign C_DO        = g_stage[STAGES-1].c_q;
    assign OutValid_SO = g_stage[STAGES-1].vld_q;
    assign V_DO        = g_stage[STAGES-1].g_flags.v_q;
    assign Z_DO        = g_stage[STAGES-1].g_flags.z_q;
endmodule

// File: doc/adder_pipelined_structural.md
Name: adder_pipelined_structural

Overview:
- Parametrised, pipelined ripple-carry add/subtract unit; the multi-bit, multi-cycle successor to the 1-bit full-adder cell.
- Operand width is split into STAGES equal chunks. Each pipeline stage ripples the carry through one chunk using full-adder cells, then registers the carry into the next stage.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Adds subtract mode, plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be ≥ 2 and divisible by STAGES.
- STAGES, 4: number of pipeline register stages; 1 ≤ STAGES ≤ WIDTH. Chunk width is CW = WIDTH/STAGES.

Ports:
- Clk_CI  input  1  clock; all registers update on the rising edge.
- Rst_RBI  input  1  asynchronous, active-low reset.
- A_DI  input  WIDTH  operand A (unsigned or two's complement).
- B_DI  input  WIDTH  operand B.
- C_DI  input  1  carry-in; used only when Sub_SI=0.
- Sub_SI  input  1  0 = add, 1 = subtract.
- InValid_SI  input  1  operand beat valid.
- InReady_SO  output  1  unit accepts a beat this cycle.
- S_DO  output  WIDTH  result.
- C_DO  output  1  carry-out of MSB. In subtract mode this is 1 when no borrow occurred (A ≥ B unsigned).
- V_DO  output  1  signed overflow.
- Z_DO  output  1  result == 0.
- OutValid_SO  output  1  result beat valid.
- OutReady_SI  input  1  consumer accepts the result.

Behaviour:
- Reset: all stage valid bits, all data and carry registers, S_DO, C_DO, V_DO, Z_DO and OutValid_SO go to 0 immediately on Rst_RBI=0, independent of the clock. InReady_SO is 1 while the pipeline is empty.
- Arithmetic:
  - Add: {C_DO,S_DO} = A + B + C_DI.
  - Subtract: {C_DO,S_DO} = A + ~B + 1; C_DI is ignored.
  - V_DO = (A[MSB] == B'[MSB]) & (S[MSB] != A[MSB]), where B' is the effective (possibly inverted) B.
  - Z_DO = (S == 0), independent of carry.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) computes bits [k*CW +: CW] from the registered carry of stage k-1. Stage 0 uses C_DI, or 1 when subtracting.
  - Unprocessed upper operand chunks travel forward in skew registers. Finished lower result chunks are held in de-skew registers.
  - No combinational carry path crosses a stage register.
- Flags: V_DO and Z_DO are computed in the final stage and registered with S_DO.
- Latency: exactly STAGES cycles from an accepted input beat to OutValid_SO=1, when there is no back-pressure. Throughput is one beat per cycle.
- Handshake:
  - advance = OutReady_SI | ~OutValid_SO; InReady_SO = advance.
  - A beat is accepted when InValid_SI & InReady_SO.
  - When advance=0, all stages hold: data, valid bits and outputs stay stable.
  - The producer must hold A, B, C and Sub stable while InValid_SI=1 and InReady_SO=0.
  - A result transfers when OutValid_SO & OutReady_SI. On that edge the next stage contents, or a bubble, move in.
- Bubbles: an invalid beat propagates as valid=0. Bubbles are not compacted except at the output, through the advance term.
- Simultaneous events: an output pop and an input accept in the same cycle are both performed; the pipeline stays full.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. After Rst_RBI rises, first acceptance is possible on the next rising edge.
- Wrap-around: the result wraps modulo 2^WIDTH; the carry is reported only via C_DO.
- STAGES=1 degenerates to a registered full-width ripple adder with 1-cycle latency.

Test Plan:
- WIDTH=8, STAGES=2, add: A=0x7F, B=0x01, C=0 → after 2 cycles S=0x80, C=0, V=1, Z=0.
- Add with carry-in and wrap: A=0xFF, B=0x00, C=1 → S=0x00, C=1, V=0, Z=1. Carry must cross the chunk boundary at bit 4.
- Subtract: A=0x05, B=0x07, Sub=1, C=1 (ignored) → S=0xFE, C=0, V=0. Then A=0x80, B=0x01 → S=0x7F, C=1, V=1.
- Back-to-back stream with back-pressure:
  - Stimulus: 6 consecutive beats; OutReady_SI=0 for 3 cycles after the first result appears.
  - Required response: outputs stay stable and InReady_SO=0 while stalled, all 6 results arrive in order with none lost or duplicated, and the unit sustains 1 beat per cycle once OutReady_SI=1.
- Reset mid-flight: assert Rst_RBI=0 between clock edges while 2 beats are in flight → OutValid_SO and S_DO drop to 0 immediately, and no stale result appears after release.
- Randomised sweep: 10k beats with random A, B, C and Sub, across the configurations WIDTH/STAGES = 32/4, 32/1, 16/16 → every result matches the reference model, with random OutReady_SI.
